// File: rtl/qq_head.sv
// qq_head: root controller and client front-end for the QuickQ node chain.
//
// Holds the current minimum key in a root register. It forwards displaced keys
// down to the level-0 node with enq_o/data_o and requests promotions with deq_o.
// The root is refilled from data_i in the last cycle of the dequeue wait. The
// block also owns occupancy (count/full/empty) and the node-chain issue
// interval II.
//
// Ports:
//   clk, rst (async, active low)
//   enq_req, deq_req, key_i     user requests, qualified by ready
//   ready, deq_valid, deq_data  user handshake / dequeued key
//   full, empty, count, err     occupancy and sticky misuse flag
//   enq_o, deq_o, data_o        commands to level-0 node
//   data_i                      key promoted from level 0
//
// Build option: define QQ_HEAD_ERR_EN to build the sticky misuse detector.
// Without it, err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a user operation
// ENQ_WAIT | enqueue forwarded to level 0; holding off for the issue interval
// DEQ_WAIT | promotion requested; root reloads from data_i on the last cycle

module qq_head #(
   parameter int W  = 8,
   parameter int D  = 16,
   parameter int II = 4,
   localparam int CW = $clog2(D + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enq_req,
   input  logic          deq_req,
   input  logic [W-1:0]  key_i,
   output logic          ready,
   output logic          deq_valid,
   output logic [W-1:0]  deq_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          err,
   output logic          enq_o,
   output logic          deq_o,
   output logic [W-1:0]  data_o,
   input  logic [W-1:0]  data_i
);

   localparam int IW = (II > 2) ? $clog2(II - 1) : 1;
   localparam logic [W-1:0] MAX_KEY = '1;

   typedef enum logic [1:0] {S_IDLE, S_ENQ_WAIT, S_DEQ_WAIT} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ivl_q, ivl_d;
   logic [W-1:0]  root_q, root_d;
   logic [CW-1:0] count_q, count_d;
   logic          enq_o_q, enq_o_d;
   logic          deq_o_q, deq_o_d;
   logic [W-1:0]  data_o_q, data_o_d;
   logic          deq_valid_q, deq_valid_d;
   logic [W-1:0]  deq_data_q, deq_data_d;
   logic          enq_acc, deq_acc;
   logic          key_lt_root;

   assign ready = (state_q == S_IDLE);
   assign full  = (count_q == CW'(D));
   assign empty = (count_q == '0);

   assign deq_acc     = deq_req & ready & ~empty;
   assign enq_acc     = enq_req & ready & ~full & ~(deq_req & ~empty);
   // Strict compare: on a tie the incoming key is the one sent down.
   assign key_lt_root = (key_i < root_q);

   always_comb begin
      state_d     = state_q;
      ivl_d       = ivl_q;
      root_d      = root_q;
      count_d     = count_q;
      deq_data_d  = deq_data_q;
      enq_o_d     = 1'b0;
      deq_o_d     = 1'b0;
      data_o_d    = '0;
      deq_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (deq_acc) begin
               deq_valid_d = 1'b1;
               deq_data_d  = root_q;
               count_d     = count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  root_d = MAX_KEY;
               end else begin
                  deq_o_d = 1'b1;
                  ivl_d   = IW'(II - 2);
                  state_d = S_DEQ_WAIT;
               end
            end else if (enq_acc) begin
               count_d = count_q + CW'(1);
               if (count_q == '0) begin
                  root_d = key_i;
               end else begin
                  root_d   = key_lt_root ? key_i : root_q;
                  data_o_d = key_lt_root ? root_q : key_i;
                  enq_o_d  = 1'b1;
                  ivl_d    = IW'(II - 2);
                  state_d  = S_ENQ_WAIT;
               end
            end
         end
         S_ENQ_WAIT, S_DEQ_WAIT: begin
            if (ivl_q == '0) begin
               state_d = S_IDLE;
               if (state_q == S_DEQ_WAIT) root_d = data_i;
            end else begin
               ivl_d = ivl_q - IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ivl_q       <= '0;
         root_q      <= MAX_KEY;
         count_q     <= '0;
         enq_o_q     <= 1'b0;
         deq_o_q     <= 1'b0;
         data_o_q    <= '0;
         deq_valid_q <= 1'b0;
         deq_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ivl_q       <= ivl_d;
         root_q      <= root_d;
         count_q     <= count_d;
         enq_o_q     <= enq_o_d;
         deq_o_q     <= deq_o_d;
         data_o_q    <= data_o_d;
         deq_valid_q <= deq_valid_d;
         deq_data_q  <= deq_data_d;
      end
   end

   assign count     = count_q;
   assign enq_o     = enq_o_q;
   assign deq_o     = deq_o_q;
   assign data_o    = data_o_q;
   assign deq_valid = deq_valid_q;
   assign deq_data  = deq_data_q;

`ifdef QQ_HEAD_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (enq_req & ready & full) | (deq_req & ready & empty & ~enq_acc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/qq_head.md
# qq_head

Root controller and client front-end for the QuickQ node chain. It accepts enqueue and dequeue requests from the user side and keeps the current minimum key in a root register. It issues `enq_o`/`deq_o` commands with keys down to the level-0 `qq_node`, and refills the root from the key that level promotes after a dequeue. It owns occupancy, full/empty and the minimum issue interval the node chain requires between operations.

## Interface
Parameters:
- `W`, 8, key width in bits
- `D`, 16, total queue capacity in keys, root included; D ≥ 2
- `II`, 4, minimum node-chain issue interval in cycles; II ≥ 2
- `CW`, $clog2(D+1), occupancy counter width (localparam)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (low = reset asserted)
- `enq_req`  in  1  user enqueue request, level, qualified by `ready`
- `deq_req`  in  1  user dequeue request, level, qualified by `ready`
- `key_i`  in  W  key to enqueue; smaller value = higher priority
- `ready`  out  1  head can accept an operation this cycle
- `deq_valid`  out  1  one-cycle pulse: `deq_data` holds the dequeued key
- `deq_data`  out  W  dequeued (minimum) key
- `full`  out  1  `count == D`
- `empty`  out  1  `count == 0`
- `count`  out  CW  keys currently held
- `err`  out  1  sticky misuse flag (see Configuration)
- `enq_o`  out  1  one-cycle enqueue command to level 0
- `deq_o`  out  1  one-cycle dequeue command to level 0
- `data_o`  out  W  key accompanying `enq_o`; 0 when idle
- `data_i`  in  W  key promoted from level 0; valid in cycle T+II-1 after a `deq_o` issued at T+1

## Operation
- The root register holds the minimum key. It holds MAX_KEY (all ones) when empty. Empty is tracked by `count`, not by the key value.
- FSM states: IDLE, ENQ_WAIT, DEQ_WAIT. A down-counter `ivl` times the wait states. `ready = (state == IDLE)`.
- Accepted enqueue: `enq_req & ready & !full & !(deq_req & !empty)`.
- Accepted dequeue: `deq_req & ready & !empty`. Dequeue wins when both are requested. The enqueue request is then not accepted and stays pending.
- Enqueue with `count == 0`: root <= key_i. No downstream command. Stay IDLE.
- Enqueue with `count > 0`:
  - root <= min(root, key_i).
  - Next cycle: `enq_o = 1`, `data_o = max(root, key_i)`.
  - Go to ENQ_WAIT.
  - Equal keys: the incoming key goes down.
- Dequeue:
  - Next cycle: `deq_valid = 1`, `deq_data = root`.
  - If `count == 1`: root <= MAX_KEY, stay IDLE.
  - Otherwise: `deq_o = 1` in that same next cycle, go to DEQ_WAIT. In the last DEQ_WAIT cycle, root <= `data_i`.
- `count` increments on an accepted enqueue and decrements on an accepted dequeue, both in the acceptance cycle. It never wraps.
- Requests while `ready = 0`, enqueue while full, or dequeue while empty are ignored: no state change, no downstream command.

## Timing
- Reset values: root = MAX_KEY, state = IDLE, `count` = 0, `ready` = 1, `empty` = 1, `full` = 0, `enq_o` = `deq_o` = 0, `data_o` = 0, `deq_valid` = 0, `deq_data` = 0, `err` = 0.
- Reset asserted mid-operation aborts immediately to the reset values. Any half-issued downstream command is lost. The node chain shares the same reset.
- Acceptance in cycle T, with a downstream op:
  - `enq_o`/`deq_o` is high in T+1 only.
  - `ready` is low in T+1 … T+II-1 and high again in T+II.
  - Back-to-back downstream issues are therefore spaced exactly II cycles apart.
- Ops with no downstream command (first enqueue, last dequeue) can repeat every cycle. `ready` stays high.
- `deq_valid` latency is 1 cycle from acceptance in every case.
- `full`, `empty` and `count` are registered and reflect the acceptance in cycle T from T+1.
- `data_o` returns to 0 the cycle after `enq_o`.

## Configuration
- Macro `QQ_HEAD_ERR_EN`.
- Defined: `err` sets on any of the following and stays set until reset:
  - `enq_req & ready & full`
  - `deq_req & ready & empty` with no enqueue accepted that cycle
- Not defined: `err` is tied to 0 and no detection logic is built.
- All other behaviour is identical in both builds.

## Test plan
- Reset release → `ready` = 1, `empty` = 1, `count` = 0, root = 0xFF, no `enq_o`/`deq_o`.
- Enqueue 0x40 → no `enq_o`, `count` = 1. Enqueue 0x10 → `enq_o` at T+1 with `data_o` = 0x40, `ready` low for II-1 cycles, root = 0x10.
- With {0x10, 0x40} held, dequeue at T → `deq_valid` T+1 with `deq_data` = 0x10, `deq_o` at T+1. Bench model drives `data_i` = 0x40 in T+II-1 → root = 0x40, `count` = 1.
- `enq_req` and `deq_req` both high while not empty → only the dequeue is accepted. The held enqueue is accepted at the next `ready`.
- Fill to D = 16, then enqueue 0x05 → ignored, `full` stays 1, `count` = 16. `err` = 1 only in a build with `QQ_HEAD_ERR_EN`.
- Assert `rst` low during DEQ_WAIT → all outputs return to reset values within the same cycle. No further `deq_o` or root load occurs.
